memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access.sv | 249 ++++++++++++++++++++++++
 tb/tb_memory_access.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// rtl/memory_access.sv - load/store unit: decodes MIPS-style memory ops, drives a req/ack bus, returns write-back data.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned half/word accesses fault without a bus request.
module memory_access #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] ins,
    input  logic        is_load_store,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam logic [7:0] TO_LAST = 8'(BUS_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wb_valid_q, wb_valid_d;
    logic        fault_q, fault_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        ld_q, ld_d;
    logic        sgn_q, sgn_d;
    size_t       size_q, size_d;
    logic [1:0]  lane_q, lane_d;

    logic [5:0]  opcode;
    logic        dec_mem;
    logic        dec_load;
    logic        dec_signed;
    size_t       dec_size;
    logic        dec_misalign;
    logic [3:0]  dec_be;
    logic [31:0] dec_wdata;

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic        stall_c;

    logic        unused_ins;
    assign unused_ins = ^ins[25:0];

    assign opcode = ins[31:26];

    always_comb begin
        dec_mem    = 1'b0;
        dec_load   = 1'b0;
        dec_signed = 1'b0;
        dec_size   = SZ_WORD;
        if (is_load_store) begin
            case (opcode)
                OP_LB:  begin dec_mem = 1'b1; dec_load = 1'b1; dec_signed = 1'b1; dec_size = SZ_BYTE; end
                OP_LH:  begin dec_mem = 1'b1; dec_load = 1'b1; dec_signed = 1'b1; dec_size = SZ_HALF; end
                OP_LW:  begin dec_mem = 1'b1; dec_load = 1'b1; dec_size = SZ_WORD; end
                OP_LBU: begin dec_mem = 1'b1; dec_load = 1'b1; dec_size = SZ_BYTE; end
                OP_LHU: begin dec_mem = 1'b1; dec_load = 1'b1; dec_size = SZ_HALF; end
                OP_SB:  begin dec_mem = 1'b1; dec_size = SZ_BYTE; end
                OP_SH:  begin dec_mem = 1'b1; dec_size = SZ_HALF; end
                OP_SW:  begin dec_mem = 1'b1; dec_size = SZ_WORD; end
                default: dec_mem = 1'b0;
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign dec_misalign = dec_mem &&
                          (((dec_size == SZ_HALF) && addr[0]) ||
                           ((dec_size == SZ_WORD) && (addr[1:0] != 2'b00)));
`else
    assign dec_misalign = 1'b0;
`endif

    // Reads always fetch the full word; lane selection happens on return.
    always_comb begin
        dec_be    = 4'b1111;
        dec_wdata = store_data;
        if (!dec_load) begin
            case (dec_size)
                SZ_BYTE: begin
                    dec_be    = 4'b0001 << addr[1:0];
                    dec_wdata = {4{store_data[7:0]}};
                end
                SZ_HALF: begin
                    dec_be    = 4'b0011 << {addr[1], 1'b0};
                    dec_wdata = {2{store_data[15:0]}};
                end
                default: begin
                    dec_be    = 4'b1111;
                    dec_wdata = store_data;
                end
            endcase
        end
    end

    always_comb begin
        case (lane_q)
            2'd0:    rd_byte = bus_rdata[7:0];
            2'd1:    rd_byte = bus_rdata[15:8];
            2'd2:    rd_byte = bus_rdata[23:16];
            default: rd_byte = bus_rdata[31:24];
        endcase
        rd_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_val = {{24{sgn_q & rd_byte[7]}}, rd_byte};
            SZ_HALF: load_val = {{16{sgn_q & rd_half[15]}}, rd_half};
            default: load_val = bus_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wb_valid_d  = 1'b0;
        fault_d     = 1'b0;
        wb_data_d   = wb_data_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        ld_d        = ld_q;
        sgn_d       = sgn_q;
        size_d      = size_q;
        lane_d      = lane_q;
        stall_c     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (valid) begin
                    if (!dec_mem) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = addr;
                    end else if (dec_misalign) begin
                        wb_valid_d = 1'b1;
                        fault_d    = 1'b1;
                        wb_data_d  = 32'd0;
                    end else begin
                        stall_c     = 1'b1;
                        state_d     = S_REQ;
                        cnt_d       = 8'd0;
                        bus_we_d    = ~dec_load;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = dec_be;
                        bus_wdata_d = dec_wdata;
                        ld_d        = dec_load;
                        sgn_d       = dec_signed;
                        size_d      = dec_size;
                        lane_d      = addr[1:0];
                    end
                end
            end
            S_REQ: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                // An ack arriving on the final allowed cycle still wins over the timeout.
                if (bus_ack) begin
                    state_d    = S_DONE;
                    wb_valid_d = 1'b1;
                    wb_data_d  = ld_q ? load_val : 32'd0;
                end else if (cnt_q == TO_LAST) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    fault_d    = 1'b1;
                    wb_data_d  = 32'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            wb_valid_q  <= 1'b0;
            fault_q     <= 1'b0;
            wb_data_q   <= 32'd0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            ld_q        <= 1'b0;
            sgn_q       <= 1'b0;
            size_q      <= SZ_WORD;
            lane_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wb_valid_q  <= wb_valid_d;
            fault_q     <= fault_d;
            wb_data_q   <= wb_data_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            ld_q        <= ld_d;
            sgn_q       <= sgn_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
        end
    end

    assign stall     = stall_c & ~rst;
    assign wb_valid  = wb_valid_q;
    assign wb_data   = wb_data_q;
    assign fault     = fault_q;
    assign bus_req   = (state_q == S_REQ);
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - scoreboard bench for memory_access with randomized ops and a reference model.
module tb_memory_access;

    localparam int TO = 4;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SW  = 6'b101011;

    logic        sys_clk = 1'b0;
    logic        rst, valid, is_load_store, bus_ack;
    logic [31:0] ins, addr, store_data, bus_rdata;
    logic        stall, wb_valid, fault, bus_req, bus_we;
    logic [31:0] wb_data, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    memory_access #(.BUS_TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .rst(rst), .valid(valid), .ins(ins),
        .is_load_store(is_load_store), .addr(addr), .store_data(store_data),
        .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .fault(fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] data;
        logic        flt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int op_size(input logic [5:0] op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic bit op_is_load(input logic [5:0] op);
        return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] op, input int lane, input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * lane)) & 32'hFF;
        h = (rd >> (8 * (lane & 2))) & 32'hFFFF;
        case (op)
            LB:      return (b >= 128) ? b - 32'd256 : b;
            LBU:     return b;
            LH:      return (h >= 32768) ? h - 32'd65536 : h;
            LHU:     return h;
            default: return rd;
        endcase
    endfunction

    always @(negedge sys_clk) begin
        if (wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_wb: got data %h fault %b, expected no write-back", wb_data, fault);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_data", wb_data, mon_e.data);
                check("wb_fault", {31'd0, fault}, {31'd0, mon_e.flt});
            end
        end else begin
            check("fault_without_wb", {31'd0, fault}, 32'd0);
        end
    end

    // Called at a negedge; returns at the negedge where the result is visible.
    task automatic run_op(input logic [5:0] op, input logic ls, input logic [31:0] a,
                          input logic [31:0] sd, input int ack_at, input logic [31:0] rd);
        int          sz;
        int          lane;
        bit          mis;
        bit          ld;
        exp_t        e;
        logic [3:0]  xbe;
        logic [31:0] xwd;
        sz   = ls ? op_size(op) : 0;
        lane = int'(a[1:0]);
        ld   = op_is_load(op);
        mis  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = ((sz == 2) && (a % 2 != 0)) || ((sz == 4) && (a % 4 != 0));
`endif
        valid         = 1'b1;
        ins           = {op, 26'($urandom)};
        is_load_store = ls;
        addr          = a;
        store_data    = sd;
        #1;
        if (sz == 0 || mis) begin
            check("stall_no_bus", {31'd0, stall}, 32'd0);
            e.data = (sz == 0) ? a : 32'd0;
            e.flt  = mis;
            exp_q.push_back(e);
            @(negedge sys_clk);
            valid = 1'b0;
            check("no_bus_req", {31'd0, bus_req}, 32'd0);
            return;
        end
        check("stall_accept", {31'd0, stall}, 32'd1);
        if (ld) begin
            xbe = 4'hF;
            xwd = sd;
        end else if (sz == 1) begin
            xbe = 4'(1 << lane);
            xwd = (sd & 32'hFF) * 32'h01010101;
        end else if (sz == 2) begin
            xbe = 4'(3 << (lane & 2));
            xwd = (sd & 32'hFFFF) * 32'h00010001;
        end else begin
            xbe = 4'hF;
            xwd = sd;
        end
        @(negedge sys_clk);
        valid = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            check("req_bus_req", {31'd0, bus_req}, 32'd1);
            check("req_stall", {31'd0, stall}, 32'd1);
            if (k == 1) begin
                check("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
                check("bus_we", {31'd0, bus_we}, {31'd0, !ld});
                check("bus_be", {28'd0, bus_be}, {28'd0, xbe});
                if (!ld) check("bus_wdata", bus_wdata, xwd);
            end
            if (k == ack_at) begin
                bus_ack   = 1'b1;
                bus_rdata = rd;
                e.data    = ld ? model_load(op, lane, rd) : 32'd0;
                e.flt     = 1'b0;
                exp_q.push_back(e);
                @(negedge sys_clk);
                bus_ack = 1'b0;
                break;
            end
            if (k == TO) begin
                e.data = 32'd0;
                e.flt  = 1'b1;
                exp_q.push_back(e);
            end
            @(negedge sys_clk);
        end
        check("done_bus_req", {31'd0, bus_req}, 32'd0);
        check("done_stall", {31'd0, stall}, 32'd0);
    endtask

    logic [5:0] mem_ops [8]   = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
    logic [5:0] other_ops [5] = '{6'h00, 6'h08, 6'h22, 6'h2A, 6'h0F};

    initial begin
        rst = 1'b1; valid = 1'b0; ins = 32'd0; is_load_store = 1'b0;
        addr = 32'd0; store_data = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        repeat (3) @(negedge sys_clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_bus_we", {31'd0, bus_we}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_be", {28'd0, bus_be}, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        rst = 1'b0;
        @(negedge sys_clk);

        run_op(LW, 1'b1, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        run_op(LB, 1'b1, 32'h103, 32'h0, 1, 32'h80112233);
        run_op(LBU, 1'b1, 32'h103, 32'h0, 2, 32'h80112233);
        run_op(SH, 1'b1, 32'h202, 32'h0000ABCD, 1, 32'h0);
        run_op(LW, 1'b1, 32'h40, 32'h0, 99, 32'h0);
        run_op(LW, 1'b1, 32'h44, 32'h0, TO, 32'h12345678);

        @(negedge sys_clk);
        valid = 1'b1; ins = {LW, 26'd0}; is_load_store = 1'b1; addr = 32'h300;
        @(negedge sys_clk);
        valid = 1'b0;
        check("rstreq_bus_req_before", {31'd0, bus_req}, 32'd1);
        rst = 1'b1;
        @(negedge sys_clk);
        check("rstreq_bus_req_after", {31'd0, bus_req}, 32'd0);
        check("rstreq_wb_valid", {31'd0, wb_valid}, 32'd0);
        rst = 1'b0;
        run_op(6'h00, 1'b0, 32'h55, 32'h0, 1, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
        run_op(LW, 1'b1, 32'h101, 32'h0, 1, 32'h0);
`endif

        for (int i = 0; i < 300; i++) begin
            logic [5:0] op;
            logic       ls;
            if ($urandom_range(0, 3) == 0) begin
                op = other_ops[$urandom_range(0, 4)];
                ls = 1'($urandom);
            end else begin
                op = mem_ops[$urandom_range(0, 7)];
                ls = 1'b1;
            end
            run_op(op, ls, $urandom, $urandom, $urandom_range(1, TO + 2), $urandom);
            if ($urandom_range(0, 2) == 0) begin
                bus_ack   = 1'($urandom);
                bus_rdata = $urandom;
                @(negedge sys_clk);
                bus_ack = 1'b0;
            end
        end

        repeat (4) @(negedge sys_clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
